// File: rtl/game_flow_ctrl_pkg.sv
// Shared definitions for the Arkanoid game sequencer: phase encoding and counter widths.
package game_flow_ctrl_pkg;

    typedef enum logic [2:0] {
        S_TITLE  = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_SERVE  = 3'd3,
        S_PLAY   = 3'd4,
        S_LOST   = 3'd5,
        S_OVER   = 3'd6,
        S_CLEAR  = 3'd7
    } state_t;

    localparam int LIVES_W  = 2;
    localparam int LEVEL_W  = 3;
    localparam int BLOCKS_W = 8;
    localparam int HOLD_W   = 8;

endpackage

// File: rtl/game_flow_ctrl_hold_timer.sv
// Frame-paced hold timer for the life-lost and level-cleared screens.
// Counts frame ticks from a clear, saturates at all-ones, flags expiry on the final tick.
module frame_hold_timer
    import game_flow_ctrl_pkg::*;
#(
    parameter int HOLD_FRAMES = 120
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_done
);

    logic [HOLD_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_tick && (r_count != {HOLD_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry is the tick that would take the count to HOLD_FRAMES.
    assign o_done = i_tick && (r_count == HOLD_W'(HOLD_FRAMES - 1));

endmodule

// File: rtl/game_flow_ctrl.sv
// Game phase sequencer: title/serve/play/lost/over/clear, lives and level bookkeeping,
// overlay flags and one-cycle load/re-home strobes. All outputs decode registered state.
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int LIVES       = 3,
    parameter int NUM_LEVELS  = 4,
    parameter int HOLD_FRAMES = 120
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_frame_tick,
    input  logic                i_btn_start,
    input  logic                i_ball_lost,
    input  logic [BLOCKS_W-1:0] i_blocks_left,
    output logic                o_init,
    output logic                o_dead,
    output logic                o_win,
    output logic                o_play_en,
    output logic                o_serve,
    output logic                o_load_level,
    output logic                o_reset_ball,
    output logic [LIVES_W-1:0]  o_lives,
    output logic [LEVEL_W-1:0]  o_level
);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_btn_q;
    logic [LIVES_W-1:0]   r_lives;
    logic [LIVES_W-1:0]   w_lives_next;
    logic [LEVEL_W-1:0]   r_level;
    logic [LEVEL_W-1:0]   w_level_next;
    logic                 r_settle;
    logic                 w_settle_next;
    logic                 r_reset_ball;
    logic                 w_reset_ball_next;

    logic                 w_start_rise;
    logic                 w_hold_clear;
    logic                 w_hold_done;
    logic                 w_final_level;

    assign w_start_rise  = i_btn_start & ~r_btn_q;
    assign w_final_level = (r_level >= LEVEL_W'(NUM_LEVELS - 1));
    // Holding the timer clear outside the hold screens gives a fresh count on every entry.
    assign w_hold_clear  = (r_state != S_LOST) && (r_state != S_CLEAR);

    frame_hold_timer #(
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_hold (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_hold_clear),
        .i_tick  (i_frame_tick),
        .o_done  (w_hold_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_TITLE;
            r_btn_q      <= 1'b1;
            r_lives      <= LIVES_W'(LIVES);
            r_level      <= '0;
            r_settle     <= 1'b0;
            r_reset_ball <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_btn_q      <= i_btn_start;
            r_lives      <= w_lives_next;
            r_level      <= w_level_next;
            r_settle     <= w_settle_next;
            r_reset_ball <= w_reset_ball_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_lives_next      = r_lives;
        w_level_next      = r_level;
        w_settle_next     = 1'b0;
        w_reset_ball_next = 1'b0;

        case (r_state)
            S_TITLE: begin
                if (w_start_rise) begin
                    w_state_next = S_LOAD;
                    w_lives_next = LIVES_W'(LIVES);
                    w_level_next = '0;
                end
            end
            S_LOAD: begin
                w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_settle) begin
                    w_state_next = S_SERVE;
                end else begin
                    w_settle_next = 1'b1;
                end
            end
            S_SERVE: begin
                if (w_start_rise) begin
                    w_state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                // A cleared board wins even if the ball drops in the same cycle.
                if (i_blocks_left == '0) begin
                    w_state_next = S_CLEAR;
                end else if (i_ball_lost) begin
                    if (r_lives > LIVES_W'(1)) begin
                        w_state_next = S_LOST;
                        w_lives_next = r_lives - 1'b1;
                    end else begin
                        w_state_next = S_OVER;
                        w_lives_next = '0;
                    end
                end
            end
            S_LOST: begin
                if (w_hold_done) begin
                    w_state_next      = S_SERVE;
                    w_reset_ball_next = 1'b1;
                end
            end
            S_OVER: begin
                if (w_start_rise) begin
                    w_state_next = S_TITLE;
                end
            end
            S_CLEAR: begin
                if (!w_final_level) begin
                    if (w_hold_done) begin
                        w_state_next = S_LOAD;
                        w_level_next = r_level + 1'b1;
                    end
                end else if (w_start_rise) begin
                    w_state_next = S_TITLE;
                end
            end
            default: begin
                w_state_next = S_TITLE;
            end
        endcase

        if (w_state_next == S_LOAD) begin
            w_reset_ball_next = 1'b1;
        end
    end

    assign o_init       = (r_state == S_TITLE);
    assign o_dead       = (r_state == S_LOST) || (r_state == S_OVER);
    assign o_win        = (r_state == S_CLEAR);
    assign o_play_en    = (r_state == S_PLAY);
    assign o_serve      = (r_state == S_SERVE);
    assign o_load_level = (r_state == S_LOAD);
    assign o_reset_ball = r_reset_ball;
    assign o_lives      = r_lives;
    assign o_level      = r_level;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: walks title, serve, play, lost, over and clear phases.
module tb_game_flow_ctrl;

    logic       clock;
    logic       reset;
    logic       i_frame_tick;
    logic       i_btn_start;
    logic       i_ball_lost;
    logic [7:0] i_blocks_left;
    logic       o_init;
    logic       o_dead;
    logic       o_win;
    logic       o_play_en;
    logic       o_serve;
    logic       o_load_level;
    logic       o_reset_ball;
    logic [1:0] o_lives;
    logic [2:0] o_level;

    int n_checks = 0;
    int n_fail   = 0;

    // {init, dead, win, play_en, serve, load_level, reset_ball}
    localparam logic [6:0] F_TITLE    = 7'b1000000;
    localparam logic [6:0] F_LOAD     = 7'b0000011;
    localparam logic [6:0] F_SETTLE   = 7'b0000000;
    localparam logic [6:0] F_SERVE    = 7'b0000100;
    localparam logic [6:0] F_SERVE_RB = 7'b0000101;
    localparam logic [6:0] F_PLAY     = 7'b0001000;
    localparam logic [6:0] F_DEAD     = 7'b0100000;
    localparam logic [6:0] F_WIN      = 7'b0010000;

    logic [6:0] w_flags;
    assign w_flags = {o_init, o_dead, o_win, o_play_en, o_serve, o_load_level, o_reset_ball};

    game_flow_ctrl #(
        .LIVES       (3),
        .NUM_LEVELS  (4),
        .HOLD_FRAMES (120)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .i_frame_tick  (i_frame_tick),
        .i_btn_start   (i_btn_start),
        .i_ball_lost   (i_ball_lost),
        .i_blocks_left (i_blocks_left),
        .o_init        (o_init),
        .o_dead        (o_dead),
        .o_win         (o_win),
        .o_play_en     (o_play_en),
        .o_serve       (o_serve),
        .o_load_level  (o_load_level),
        .o_reset_ball  (o_reset_ball),
        .o_lives       (o_lives),
        .o_level       (o_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Release then press; on return the edge that saw the rise has just happened.
    task automatic press();
        i_btn_start = 1'b0;
        step();
        i_btn_start = 1'b1;
        step();
        i_btn_start = 1'b0;
    endtask

    // From a just-entered S_LOAD through settle, serve and into play.
    task automatic load_to_play(input string tag, input logic [2:0] exp_level);
        check({tag, " load flags"}, 32'(w_flags), 32'(F_LOAD));
        check({tag, " level"}, 32'(o_level), 32'(exp_level));
        step();
        check({tag, " settle1"}, 32'(w_flags), 32'(F_SETTLE));
        step();
        check({tag, " settle2"}, 32'(w_flags), 32'(F_SETTLE));
        step();
        check({tag, " serve"}, 32'(w_flags), 32'(F_SERVE));
        press();
        check({tag, " play"}, 32'(w_flags), 32'(F_PLAY));
    endtask

    // Lose a ball from play with lives remaining, then ride out the hold.
    task automatic lose_life(input string tag, input logic [1:0] exp_lives);
        i_ball_lost = 1'b1;
        step();
        i_ball_lost = 1'b0;
        check({tag, " dead"}, 32'(w_flags), 32'(F_DEAD));
        check({tag, " lives"}, 32'(o_lives), 32'(exp_lives));
        i_frame_tick = 1'b1;
        repeat (119) step();
        check({tag, " held 119"}, 32'(w_flags), 32'(F_DEAD));
        step();
        i_frame_tick = 1'b0;
        check({tag, " exit rb"}, 32'(w_flags), 32'(F_SERVE_RB));
        step();
        check({tag, " serve"}, 32'(w_flags), 32'(F_SERVE));
    endtask

    // Clear a non-final level from play; a start press mid-hold must be ignored.
    task automatic clear_level(input string tag, input logic [2:0] next_level);
        i_blocks_left = 8'd0;
        step();
        i_blocks_left = 8'd12;
        check({tag, " win"}, 32'(w_flags), 32'(F_WIN));
        i_frame_tick = 1'b1;
        repeat (60) step();
        i_btn_start = 1'b1;
        step();
        i_btn_start = 1'b0;
        repeat (58) step();
        check({tag, " held 119"}, 32'(w_flags), 32'(F_WIN));
        step();
        i_frame_tick = 1'b0;
        load_to_play(tag, next_level);
    endtask

    initial begin
        reset         = 1'b1;
        i_frame_tick  = 1'b0;
        i_btn_start   = 1'b1;
        i_ball_lost   = 1'b0;
        i_blocks_left = 8'd12;
        step();
        step();
        reset = 1'b0;
        check("reset flags", 32'(w_flags), 32'(F_TITLE));
        check("reset lives", 32'(o_lives), 32'd3);
        check("reset level", 32'(o_level), 32'd0);

        // Button held through reset must not start the game.
        repeat (10) step();
        check("held btn title", 32'(w_flags), 32'(F_TITLE));

        press();
        load_to_play("start", 3'd0);
        check("start lives", 32'(o_lives), 32'd3);

        lose_life("lost3", 2'd2);
        i_ball_lost = 1'b1;
        step();
        i_ball_lost = 1'b0;
        check("lost in serve ignored", 32'(w_flags), 32'(F_SERVE));
        check("lost in serve lives", 32'(o_lives), 32'd2);
        press();
        check("replay", 32'(w_flags), 32'(F_PLAY));

        lose_life("lost2", 2'd1);
        press();
        check("replay2", 32'(w_flags), 32'(F_PLAY));

        i_ball_lost = 1'b1;
        step();
        i_ball_lost = 1'b0;
        check("over flags", 32'(w_flags), 32'(F_DEAD));
        check("over lives", 32'(o_lives), 32'd0);
        repeat (3) step();
        check("over stays", 32'(w_flags), 32'(F_DEAD));
        press();
        check("over to title", 32'(w_flags), 32'(F_TITLE));
        check("title lives", 32'(o_lives), 32'd0);
        press();
        check("reload lives", 32'(o_lives), 32'd3);
        load_to_play("game2", 3'd0);

        // Clear and ball loss in the same cycle: win wins, lives untouched.
        i_blocks_left = 8'd0;
        i_ball_lost   = 1'b1;
        step();
        i_blocks_left = 8'd12;
        i_ball_lost   = 1'b0;
        check("tie win", 32'(w_flags), 32'(F_WIN));
        check("tie lives", 32'(o_lives), 32'd3);
        i_frame_tick = 1'b1;
        repeat (120) step();
        i_frame_tick = 1'b0;
        load_to_play("lvl1", 3'd1);

        clear_level("lvl2", 3'd2);
        clear_level("lvl3", 3'd3);

        // Final level: the win screen persists past the hold until start.
        i_blocks_left = 8'd0;
        step();
        i_blocks_left = 8'd12;
        check("final win", 32'(w_flags), 32'(F_WIN));
        i_frame_tick = 1'b1;
        repeat (300) step();
        i_frame_tick = 1'b0;
        check("final held", 32'(w_flags), 32'(F_WIN));
        check("final level", 32'(o_level), 32'd3);
        press();
        check("final to title", 32'(w_flags), 32'(F_TITLE));

        // Reset in the middle of a clear hold.
        press();
        load_to_play("game3", 3'd0);
        i_blocks_left = 8'd0;
        step();
        i_blocks_left = 8'd12;
        i_frame_tick  = 1'b1;
        repeat (60) step();
        i_frame_tick = 1'b0;
        check("pre-reset win", 32'(w_flags), 32'(F_WIN));
        check("pre-reset hold", 32'(dut.u_hold.r_count), 32'd60);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid reset flags", 32'(w_flags), 32'(F_TITLE));
        check("mid reset level", 32'(o_level), 32'd0);
        check("mid reset lives", 32'(o_lives), 32'd3);
        check("mid reset hold", 32'(dut.u_hold.r_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
